// File: rtl/apf_wishbone_pkg.sv
// Shared Wishbone registered-feedback constants and the RAM slave state type.
package apf_wishbone_pkg;

    // Cycle type identifiers (cti)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Burst type identifiers (bte)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLASSIC = 2'd1,
        BURST   = 2'd2
    } state_t;

endpackage

// File: rtl/wishbone_burst_addr.sv
// Next burst word index: linear bursts roll over the whole RAM, wrap bursts
// increment only the low bits and keep the upper bits of the index.
module wishbone_burst_addr
    import apf_wishbone_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] index,
    input  logic [1:0]       bte,
    output logic [WIDTH-1:0] next_index
);

    logic [WIDTH-1:0] wrap_mask;
    logic [WIDTH-1:0] incremented;

    // Select which index bits take part in the increment
    always_comb begin
        wrap_mask = '1;
        case (bte)
            BTE_WRAP4:  wrap_mask = WIDTH'(4'h3);
            BTE_WRAP8:  wrap_mask = WIDTH'(4'h7);
            BTE_WRAP16: wrap_mask = WIDTH'(4'hF);
            default:    wrap_mask = '1;
        endcase
    end

    assign incremented = index + WIDTH'(1);
    assign next_index  = (index & ~wrap_mask) | (incremented & wrap_mask);

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone slave wrapping a single-port word RAM. Classic cycles complete in
// two clocks; incrementing bursts stream one beat per clock using an internal
// word index, so the address bus is only decoded on the first beat.
module wishbone_ram_slave
    import apf_wishbone_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [29:0] BASE_WORD  = 30'h0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [29:0] addr,
    input  logic [31:0] data_write,
    input  logic [3:0]  sel,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic        ack,
    output logic        err,
    output logic [31:0] data_read
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [0:DEPTH-1];
    state_t                state;
    logic [DEPTH_LOG2-1:0] burst_idx;
    logic [DEPTH_LOG2-1:0] beat_idx;
    logic [DEPTH_LOG2-1:0] next_idx;
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic [1:0]            rst_sync;
    logic                  rst_ready;
    logic                  hit;
    logic                  accept;
    logic                  beat_go;
    logic                  mem_we;

    assign addr_idx  = addr[DEPTH_LOG2-1:0];
    assign hit       = (addr[29:DEPTH_LOG2] == BASE_WORD[29:DEPTH_LOG2]);
    assign rst_ready = rst_sync[1];

    // ack/err must be low here, otherwise a master still holding stb during
    // the termination cycle would be accepted twice
    assign accept = rst_ready & cyc & stb & ~ack & ~err & (state == IDLE);

    // Reset assertion is immediate; release is held off two clock edges
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Which RAM word (if any) this edge touches
    always_comb begin
        beat_go  = 1'b0;
        beat_idx = addr_idx;
        case (state)
            IDLE: begin
                beat_go = accept & hit;
            end
            BURST: begin
                beat_go  = rst_ready & cyc & stb;
                beat_idx = burst_idx;
            end
            default: begin
                beat_go = 1'b0;
            end
        endcase
    end

    assign mem_we = beat_go & we;

    wishbone_burst_addr #(
        .WIDTH (DEPTH_LOG2)
    ) u_burst_addr (
        .index      (beat_idx),
        .bte        (bte),
        .next_index (next_idx)
    );

    // Byte-lane RAM writes; the array carries no reset so it maps onto block RAM
    always_ff @(posedge clk_sys) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    mem[beat_idx][8*b +: 8] <= data_write[8*b +: 8];
                end
            end
        end
    end

    // Transaction sequencing with registered ack/err/data_read
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            data_read <= '0;
            burst_idx <= '0;
        end else if (!rst_ready) begin
            state     <= IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            data_read <= '0;
            burst_idx <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (!cyc) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (!hit) begin
                                err <= 1'b1;
                            end else begin
                                ack <= 1'b1;
                                if (!we) begin
                                    data_read <= mem[beat_idx];
                                end
                                if (cti == CTI_INCR) begin
                                    state     <= BURST;
                                    burst_idx <= next_idx;
                                end else begin
                                    state <= CLASSIC;
                                end
                            end
                        end
                    end
                    CLASSIC: begin
                        state <= IDLE;
                    end
                    BURST: begin
                        if (stb) begin
                            ack       <= 1'b1;
                            burst_idx <= next_idx;
                            if (!we) begin
                                data_read <= mem[beat_idx];
                            end
                            if (cti == CTI_END) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Directed bench for wishbone_ram_slave. Driver tasks act as a Wishbone master
// and, per beat, predict the termination and read data from a word-array model
// of the RAM; one compare process checks outputs every cycle.
module tb_wishbone_ram_slave;
    import apf_wishbone_pkg::*;

    localparam int          DL    = 8;
    localparam int          DEPTH = 1 << DL;
    localparam logic [29:0] BASE  = 30'h400;
    localparam logic [21:0] BASE_HI = BASE[29:8];

    logic        clk_sys;
    logic        reset_n;
    logic [29:0] addr;
    logic [31:0] data_write;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err;
    logic [31:0] data_read;

    wishbone_ram_slave #(
        .DEPTH_LOG2 (DL),
        .BASE_WORD  (BASE)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .addr       (addr),
        .data_write (data_write),
        .sel        (sel),
        .cyc        (cyc),
        .stb        (stb),
        .we         (we),
        .cti        (cti),
        .bte        (bte),
        .ack        (ack),
        .err        (err),
        .data_read  (data_read)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] mdl [DEPTH];
    int          m_idx;
    logic        exp_ack, exp_err;
    logic [31:0] exp_data;
    logic        nxt_ack, nxt_err, nxt_dv;
    logic [31:0] nxt_data;
    bit          check_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Word index after idx within a burst of the given type
    function automatic int wrap_next(input int i, input logic [1:0] b);
        int span;
        case (b)
            2'b01:   span = 4;
            2'b10:   span = 8;
            2'b11:   span = 16;
            default: span = DEPTH;
        endcase
        return (i / span) * span + (i + 1) % span;
    endfunction

    // Advance one clock; what was predicted for this edge becomes the expectation
    task automatic tick();
        @(posedge clk_sys);
        #1;
        exp_ack = nxt_ack;
        exp_err = nxt_err;
        if (nxt_dv) exp_data = nxt_data;
        nxt_ack = 1'b0;
        nxt_err = 1'b0;
        nxt_dv  = 1'b0;
    endtask

    task automatic idle();
        cyc = 1'b0;
        stb = 1'b0;
        tick();
    endtask

    // Classic access; request held through the termination cycle, as a
    // master would until it samples ack/err
    task automatic classic(input bit w, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int i;
        i = int'(a[7:0]);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; data_write = d; sel = s;
        cti = CTI_CLASSIC; bte = BTE_LINEAR;
        if (a[29:8] == BASE_HI) begin
            nxt_ack = 1'b1;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
            end else begin
                nxt_dv   = 1'b1;
                nxt_data = mdl[i];
            end
        end else begin
            nxt_err = 1'b1;
        end
        tick();
        rd = data_read;
        tick();
    endtask

    // One burst beat at the model's current burst index
    task automatic beat(input bit w, input logic [31:0] d, input logic [2:0] c);
        cyc = 1'b1; stb = 1'b1; we = w; addr = BASE + 30'(m_idx);
        data_write = d; sel = 4'hF; cti = c;
        nxt_ack = 1'b1;
        if (w) mdl[m_idx] = d;
        else begin
            nxt_dv   = 1'b1;
            nxt_data = mdl[m_idx];
        end
        m_idx = wrap_next(m_idx, bte);
        tick();
    endtask

    task automatic wait_beat();
        cyc = 1'b1;
        stb = 1'b0;
        tick();
    endtask

    task automatic burst4(input bit w, input int start, input logic [1:0] b, input logic [31:0] d0);
        bte   = b;
        m_idx = start;
        for (int k = 0; k < 4; k++)
            beat(w, d0 + 32'(k), (k == 3) ? CTI_END : CTI_INCR);
        idle();
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk_sys) begin
        if (check_en) begin
            check("ack", {31'b0, ack}, {31'b0, exp_ack});
            check("err", {31'b0, err}, {31'b0, exp_err});
            if (exp_ack) check("data_read", data_read, exp_data);
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] wrap4_exp [4];
        wrap4_exp[0] = 32'd3; wrap4_exp[1] = 32'd4; wrap4_exp[2] = 32'd1; wrap4_exp[3] = 32'd2;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        cyc = 0; stb = 0; we = 0; addr = '0; data_write = '0; sel = '0;
        cti = CTI_CLASSIC; bte = BTE_LINEAR;
        exp_ack = 0; exp_err = 0; exp_data = 0;
        nxt_ack = 0; nxt_err = 0; nxt_dv = 0; nxt_data = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        check_en = 1;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (3) tick();

        // Write then immediately read back, back-to-back classic
        classic(1, BASE + 30'd5, 32'hDEADBEEF, 4'hF, rd);
        classic(0, BASE + 30'd5, 32'h0, 4'hF, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        idle();

        // Byte-lane merge; read with a partial sel still returns the whole word
        classic(1, BASE + 30'd9, 32'h11223344, 4'hF, rd);
        classic(1, BASE + 30'd9, 32'hAABBCCDD, 4'b0010, rd);
        classic(0, BASE + 30'd9, 32'h0, 4'b0001, rd);
        check("rd_sel_merge", rd, 32'h1122CC44);
        idle();

        // Out-of-region accesses terminate with err and leave the RAM alone
        classic(1, BASE, 32'hCAFE0000, 4'hF, rd);
        classic(1, BASE + 30'd255, 32'h12345678, 4'hF, rd);
        classic(0, BASE + 30'd256, 32'h0, 4'hF, rd);
        classic(1, BASE + 30'd256, 32'h0BAD0BAD, 4'hF, rd);
        classic(1, BASE - 30'd1, 32'h0BAD0BAD, 4'hF, rd);
        idle();
        classic(0, BASE, 32'h0, 4'hF, rd);
        check("rd_after_miss0", rd, 32'hCAFE0000);
        classic(0, BASE + 30'd255, 32'h0, 4'hF, rd);
        check("rd_after_miss255", rd, 32'h12345678);
        idle();

        // Wrap-4 write burst from index 6
        burst4(1, 6, BTE_WRAP4, 32'd1);
        for (int k = 0; k < 4; k++) begin
            classic(0, BASE + 30'(4 + k), 32'h0, 4'hF, rd);
            check("rd_wrap4", rd, wrap4_exp[k]);
        end
        idle();

        // Other burst types, written then read back as bursts
        burst4(1, 13, BTE_WRAP8, 32'h0800);
        burst4(0, 13, BTE_WRAP8, 32'h0);
        burst4(1, 30, BTE_WRAP16, 32'h1600);
        burst4(0, 30, BTE_WRAP16, 32'h0);
        burst4(1, 254, BTE_LINEAR, 32'hE000);
        burst4(0, 254, BTE_LINEAR, 32'h0);
        classic(0, BASE + 30'd8, 32'h0, 4'hF, rd);
        check("rd_wrap8_last", rd, 32'h0803);
        classic(0, BASE + 30'd17, 32'h0, 4'hF, rd);
        check("rd_wrap16_last", rd, 32'h1603);
        classic(0, BASE + 30'd1, 32'h0, 4'hF, rd);
        check("rd_linear_roll", rd, 32'hE003);
        idle();

        // Wait states inside a linear burst
        bte = BTE_LINEAR; m_idx = 20;
        beat(1, 32'd10, CTI_INCR);
        beat(1, 32'd11, CTI_INCR);
        wait_beat(); wait_beat();
        beat(1, 32'd12, CTI_INCR);
        beat(1, 32'd13, CTI_END);
        idle();
        m_idx = 20;
        beat(0, 32'd0, CTI_INCR);
        beat(0, 32'd0, CTI_INCR);
        wait_beat(); wait_beat();
        beat(0, 32'd0, CTI_INCR);
        beat(0, 32'd0, CTI_END);
        idle();
        classic(0, BASE + 30'd22, 32'h0, 4'hF, rd);
        check("rd_after_waits", rd, 32'd12);
        idle();

        // cyc dropped mid-burst, then a classic read must decode addr afresh
        m_idx = 20;
        beat(0, 32'd0, CTI_INCR);
        beat(0, 32'd0, CTI_INCR);
        idle();
        classic(0, BASE + 30'd23, 32'h0, 4'hF, rd);
        check("rd_after_cyc_drop", rd, 32'd13);
        idle();

        // Reset pulsed mid-burst: outputs clear at once, pending beat dropped
        classic(1, BASE + 30'd42, 32'h00004242, 4'hF, rd);
        classic(0, BASE + 30'd4, 32'h0, 4'hF, rd);
        bte = BTE_LINEAR; m_idx = 40;
        beat(1, 32'h50, CTI_INCR);
        beat(1, 32'h51, CTI_INCR);
        check("ack_before_rst", {31'b0, ack}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE + 30'd42;
        data_write = 32'h52; sel = 4'hF; cti = CTI_INCR;
        #1 reset_n = 1'b0;
        #1;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_data_read", data_read, 32'd0);
        exp_ack = 0; exp_err = 0; exp_data = 0;
        tick();
        tick();
        cyc = 1'b0; stb = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        classic(0, BASE + 30'd42, 32'h0, 4'hF, rd);
        check("rd_beat_blocked", rd, 32'h00004242);
        classic(0, BASE + 30'd41, 32'h0, 4'hF, rd);
        check("rd_beat_before_rst", rd, 32'h51);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
